// File: rtl/sort_pkg.sv
// Shared types for the sorted-stream run-length encoder.
package sort_pkg;
   localparam int DEF_DATA_W = 8;
   localparam int DEF_CNT_W  = 8;

   typedef struct packed {
      logic [DEF_DATA_W-1:0] value;
      logic [DEF_CNT_W-1:0]  count;
   } rle_pair_t;

   typedef enum logic {EMPTY, RUN} rle_state_t;
endpackage

// File: rtl/sort_rle_idle_timer.sv
// Saturating idle counter; expired once IDLE_FLUSH-1 quiet cycles have been counted.
module sort_rle_idle_timer #(
   parameter int IDLE_FLUSH = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic tick,
   output logic expired
);
   localparam int TW = $clog2(IDLE_FLUSH);
   localparam logic [TW-1:0] LAST = TW'(IDLE_FLUSH - 1);

   logic [TW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                   cnt <= '0;
      else if (clear)               cnt <= '0;
      else if (tick && cnt != LAST) cnt <= cnt + 1'b1;
   end

   assign expired = (cnt == LAST);
endmodule

// File: rtl/sort_rle.sv
// Run-length encoder for a sorted byte stream with idle flush.
// Optional descending-order detector enabled by SORT_RLE_ORDER_CHK_EN.
module sort_rle
   import sort_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int CNT_W      = DEF_CNT_W,
   parameter int IDLE_FLUSH = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sort_val,
   output logic              sort_rdy,
   input  logic [DATA_W-1:0] sort_data,
   output logic              enc_val,
   input  logic              enc_rdy,
   output logic [DATA_W-1:0] enc_data,
   output logic [CNT_W-1:0]  enc_cnt,
   output logic              order_err
);
   localparam logic [CNT_W-1:0] MAX_RUN = '1;

   typedef struct packed {
      logic [DATA_W-1:0] value;
      logic [CNT_W-1:0]  count;
   } pair_t;

   rle_state_t        state, state_nxt;
   logic [DATA_W-1:0] cur_val, cur_val_nxt;
   logic [CNT_W-1:0]  cur_cnt, cur_cnt_nxt;
   pair_t             enc_q;
   logic              accept, emit, flush, expired;

   assign sort_rdy = ~enc_val | enc_rdy;
   assign accept   = sort_val & sort_rdy;
   // accept wins over flush, so a flush only happens on a quiet cycle
   assign flush    = (state == RUN) & ~accept & expired & sort_rdy;

   sort_rle_idle_timer #(.IDLE_FLUSH(IDLE_FLUSH)) u_idle (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (accept | flush),
      .tick    (state == RUN),
      .expired (expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= EMPTY;
         cur_val <= '0;
         cur_cnt <= '0;
      end else begin
         state   <= state_nxt;
         cur_val <= cur_val_nxt;
         cur_cnt <= cur_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cur_val_nxt = cur_val;
      cur_cnt_nxt = cur_cnt;
      emit        = 1'b0;
      case (state)
         EMPTY: begin
            if (accept) begin
               cur_val_nxt = sort_data;
               cur_cnt_nxt = CNT_W'(1);
               state_nxt   = RUN;
            end
         end
         RUN: begin
            if (accept) begin
               if (sort_data == cur_val && cur_cnt != MAX_RUN) begin
                  cur_cnt_nxt = cur_cnt + 1'b1;
               end else begin
                  emit        = 1'b1;
                  cur_val_nxt = sort_data;
                  cur_cnt_nxt = CNT_W'(1);
               end
            end else if (flush) begin
               emit        = 1'b1;
               cur_cnt_nxt = '0;
               state_nxt   = EMPTY;
            end
         end
         default: state_nxt = EMPTY;
      endcase
   end

   // emit is only possible when the slot is free, so a held pair is never overwritten
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         enc_val <= 1'b0;
         enc_q   <= '0;
      end else if (emit) begin
         enc_val <= 1'b1;
         enc_q   <= '{value: cur_val, count: cur_cnt};
      end else if (enc_rdy) begin
         enc_val <= 1'b0;
      end
   end

   assign enc_data = enc_q.value;
   assign enc_cnt  = enc_q.count;

`ifdef SORT_RLE_ORDER_CHK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                            order_err <= 1'b0;
      else if (accept && state == RUN && sort_data < cur_val) order_err <= 1'b1;
   end
`else
   assign order_err = 1'b0;
`endif
endmodule

// File: doc/sort_rle.md
SORT_RLE -- requirements
Module: sort_rle

Interface
REQ-001 Parameter DATA_W, 8, width of the sorted data byte.
REQ-002 Parameter CNT_W, 8, run-count width; MAX_RUN = 2^CNT_W-1 (255).
REQ-003 Parameter IDLE_FLUSH, 16, idle cycles before a pending run is flushed; legal range 2..255.
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 sort_val  input  1  upstream sorter output valid.
REQ-007 sort_rdy  output  1  this block accepts sort_data.
REQ-008 sort_data  input  DATA_W  sorted byte from sorter.
REQ-009 enc_val  output  1  encoded pair valid.
REQ-010 enc_rdy  input  1  downstream accepts pair.
REQ-011 enc_data  output  DATA_W  run value.
REQ-012 enc_cnt  output  CNT_W  run length, 1..MAX_RUN.
REQ-013 order_err  output  1  sticky descending-order flag.

Function
REQ-014 Transfer on either side SHALL occur only on a rising clk edge with val and rdy both high.
REQ-015 sort_rdy SHALL equal (~enc_val | enc_rdy), combinationally.
REQ-016 State EMPTY: accepted byte d sets cur_val=d, cur_cnt=1, next RUN; no emit.
REQ-017 RUN, d==cur_val, cur_cnt<MAX_RUN: cur_cnt increments; no emit.
REQ-018 RUN, d==cur_val, cur_cnt==MAX_RUN: emit (cur_val,MAX_RUN); cur_cnt=1; stay RUN.
REQ-019 RUN, d!=cur_val: emit (cur_val,cur_cnt); cur_val=d, cur_cnt=1; stay RUN.
REQ-020 Emitted pair SHALL be registered: enc_val high the cycle after the terminating accept edge (latency 1).
REQ-021 enc_val/enc_data/enc_cnt SHALL hold stable while enc_val & ~enc_rdy.
REQ-022 Idle counter SHALL clear on every accept and increment each RUN cycle without accept, saturating at IDLE_FLUSH-1.
REQ-023 In RUN with idle counter at IDLE_FLUSH-1 and output slot free (~enc_val | enc_rdy), the pending run SHALL be emitted and state SHALL go EMPTY.
REQ-024 Accept and idle-flush SHALL never coincide; accept takes priority and clears the idle counter.
REQ-025 Output pair accepted downstream and new pair emitted in the same edge SHALL give back-to-back enc_val with no bubble.
REQ-026 Data SHALL never be dropped or duplicated; sum of enc_cnt equals accepted byte count after final flush.

Reset
REQ-027 rst_n low SHALL asynchronously force state EMPTY, cur_val=0, cur_cnt=0, idle counter 0, enc_val=0, enc_data=0, enc_cnt=0, order_err=0.
REQ-028 Reset mid-run SHALL discard the pending run and any un-accepted output pair; sort_rdy reads 1 during and after reset.

Configuration
REQ-029 Macro SORT_RLE_ORDER_CHK_EN defined: in RUN, accepted d<cur_val SHALL set order_err, held until reset; data path unaffected.
REQ-030 Macro undefined: order_err SHALL be tied 0 and no comparator logic synthesised.

Structure
REQ-031 Package sort_pkg SHALL hold DATA_W and CNT_W defaults, typedef rle_pair_t {value, count}, and the state enum {EMPTY, RUN}.
REQ-032 Idle counter SHALL be a sub-module sort_rle_idle_timer (inputs clear, tick, output expired).

Verification
REQ-033 Bytes 0x03,0x03,0x03,0x07 at full throughput, enc_rdy=1 -> pair (0x03,3) one cycle after 0x07 accepted; (0x07,1) after 16 idle cycles.
REQ-034 256 consecutive 0x11 -> pairs (0x11,255) then (0x11,1) after idle flush.
REQ-035 enc_rdy=0 with pair pending, new differing byte offered -> sort_rdy=0, pair held stable, no loss once enc_rdy=1.
REQ-036 rst_n pulsed low mid-run of 0x22 x5 -> all outputs 0 immediately; next byte 0x05 starts fresh run, first pair (0x05,n).
REQ-037 With SORT_RLE_ORDER_CHK_EN: 0x09 then 0x04 -> order_err=1 from following cycle until reset; pairs (0x09,1),(0x04,1) still emitted.
REQ-038 Random sorted streams, random enc_rdy -> sum of enc_cnt equals accepted count; no adjacent pairs with equal value and count<255.
